// File: rtl/register_16bit_pkg.sv
// Shared types and defaults for the parallel-load data register.
package register_16bit_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic [DATA_W-1:0] data_t;

  localparam data_t RST_DEFAULT = '0;

endpackage : register_16bit_pkg

// File: rtl/register_16bit_if.sv
// Data bus of the register: master drives d, slave returns registered q.
interface register_16bit_if #(
  parameter int unsigned WIDTH = register_16bit_pkg::DATA_W
) ();

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (output d, input  q);
  modport slave  (input  d, output q);

endinterface : register_16bit_if

// File: rtl/register_16bit_dff_sync_rst.sv
// Single-bit D flip-flop with synchronous active-high reset.
module dff_sync_rst #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic reset,
  input  logic clk,
  input  logic d,
  output logic q
);

  logic q_q;

  // Capture d each rising edge; reset wins over load and acts only at the edge.
  always_ff @(posedge clk) begin
    if (reset) q_q <= RST_VAL;
    else       q_q <= d;
  end

  assign q = q_q;

endmodule : dff_sync_rst

// File: rtl/register_16bit.sv
// Parallel-load WIDTH-bit register built from per-bit synchronous-reset flops.
module register_16bit
  import register_16bit_pkg::*;
#(
  parameter int unsigned      WIDTH       = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             reset,
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // One flop per bit so each bit of q depends only on the matching bit of d.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_sync_rst #(
      .RST_VAL (RESET_VALUE[i])
    ) u_dff (
      .reset (reset),
      .clk   (clk),
      .d     (d[i]),
      .q     (q[i])
    );
  end

endmodule : register_16bit

// File: tb/tb_register_16bit.sv
// Self-checking bench for register_16bit: table vectors plus edge-case sequences.
module tb_register_16bit;

  localparam logic [15:0] RV2 = 16'hA5C3;

  logic        clk;
  logic        reset;
  logic [15:0] q2;

  register_16bit_if #(.WIDTH(16)) bus ();

  register_16bit #(
    .WIDTH       (16),
    .RESET_VALUE (16'h0000)
  ) dut (
    .reset (reset),
    .clk   (clk),
    .d     (bus.d),
    .q     (bus.q)
  );

  // Second copy with a non-zero reset pattern exercises per-bit RST_VAL wiring.
  register_16bit #(
    .WIDTH       (16),
    .RESET_VALUE (RV2)
  ) dut2 (
    .reset (reset),
    .clk   (clk),
    .d     (bus.d),
    .q     (q2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] exp_q  [$];
  logic [15:0] exp2_q [$];
  logic [15:0] last_exp, last_exp2;
  bit          have_last;
  int          n_cmp;
  int          n_err;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector at the falling edge, confirm q has not moved yet,
  // then compare against the scoreboard just after the rising edge.
  task automatic drive(input logic r, input logic [15:0] dv, input logic [15:0] ev);
    @(negedge clk);
    reset = r;
    bus.d = dv;
    exp_q.push_back(ev);
    exp2_q.push_back(r ? RV2 : dv);
    #1;
    if (have_last) begin
      check("pre_edge_hold", bus.q, last_exp);
      check("pre_edge_hold2", q2, last_exp2);
    end
    @(posedge clk);
    #1;
    last_exp  = exp_q.pop_front();
    last_exp2 = exp2_q.pop_front();
    have_last = 1'b1;
    check("load", bus.q, last_exp);
    check("load2", q2, last_exp2);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    have_last = 1'b0;
    reset     = 1'b1;
    bus.d     = '0;

    vecs[0] = '{1'b1, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 16'h000F, 16'h000F};
    vecs[2] = '{1'b1, 16'hFFFF, 16'h0000};
    vecs[3] = '{1'b0, 16'h0001, 16'h0001};
    vecs[4] = '{1'b0, 16'h8000, 16'h8000};
    vecs[5] = '{1'b0, 16'hFFFF, 16'hFFFF};
    vecs[6] = '{1'b1, 16'h1234, 16'h0000};
    vecs[7] = '{1'b0, 16'hA5A5, 16'hA5A5};

    for (int i = 0; i < 8; i++) drive(vecs[i].rst, vecs[i].d, vecs[i].exp);

    // d toggles between edges: q must hold A5A5 until the next rising edge.
    #4 bus.d = 16'h5A5A;
    #1 check("mid_toggle", bus.q, 16'hA5A5);
    #4 bus.d = 16'hA5A5;
    #5 check("mid_toggle_back", bus.q, 16'hA5A5);
    @(posedge clk);
    #1 check("after_toggle", bus.q, 16'hA5A5);

    // Reset pulsed and dropped between edges must not clear the register.
    drive(1'b0, 16'h1234, 16'h1234);
    #4 reset = 1'b1;
    #1 check("no_async_clear", bus.q, 16'h1234);
    check("no_async_clear2", q2, 16'h1234);
    #4 reset = 1'b0;
    exp_q.push_back(16'h1234);
    exp2_q.push_back(16'h1234);
    #5 check("pulse_dropped_hold", bus.q, 16'h1234);
    @(posedge clk);
    #1;
    check("after_pulse", bus.q, exp_q.pop_front());
    check("after_pulse2", q2, exp2_q.pop_front());
    last_exp  = 16'h1234;
    last_exp2 = 16'h1234;

    // Reset then release: first edge with reset low loads d.
    drive(1'b1, 16'hC0DE, 16'h0000);
    drive(1'b0, 16'hC0DE, 16'hC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_register_16bit
